pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port id_valid  input  1  valid instruction in ID.
REQ-006 SHALL have port id_rs  input  RA_W  first source register.
REQ-007 SHALL have port id_rt  input  RA_W  second source register.
REQ-008 SHALL have port id_use_rs  input  1  rs is actually read.
REQ-009 SHALL have port id_use_rt  input  1  rt is actually read.
REQ-010 SHALL have port id_dest  input  RA_W  destination register.
REQ-011 SHALL have port id_wr  input  1  instruction writes id_dest.
REQ-012 SHALL have port id_load  input  1  instruction is a load.
REQ-013 SHALL have port flush  input  1  kill instruction in ID (branch redirect).
REQ-014 SHALL have port stall  output  1  hold IF and ID this cycle.
REQ-015 SHALL have port fwd_a  output  2  rs operand source: 00 regfile, 01 EX result, 10 MEM result.
REQ-016 SHALL have port fwd_b  output  2  rt operand source, same encoding.
REQ-017 SHALL have port stall_cnt  output  CNT_W  cumulative stall cycles.
REQ-018 SHALL have port in_stall  output  1  registered FSM state, 1 = STALL.

Function
REQ-019 SHALL keep two in-flight slots (EX, MEM), each holding valid, dest, load.
REQ-020 SHALL each cycle move EX slot to MEM slot and retire MEM slot; regfile write commits at the edge ending MEM.
REQ-021 SHALL load EX slot with {id_valid & id_wr & !stall & !flush, id_dest, id_load}; otherwise EX slot valid=0 (bubble).
REQ-022 SHALL treat a match as: slot valid, slot dest == source, source used, source != 0.
REQ-023 SHALL drive stall, fwd_a, fwd_b combinationally from registered slots and current ID inputs; zero cycles of latency.
REQ-024 SHALL force stall=0 and fwd=00 when id_valid=0 or flush=1.
REQ-025 SHALL, when both slots match the same source, give the EX slot priority (youngest producer).
REQ-026 SHALL implement FSM RUN/STALL: next state STALL when stall=1, else RUN; in_stall reflects current state.
REQ-027 SHALL increment stall_cnt by 1 every cycle with stall=1, saturating at all-ones.
REQ-028 SHALL not stall or forward on id_dest/id_rs value 0 regardless of id_wr.
REQ-029 SHALL, when flush and a would-be hazard coincide, flush wins: no stall, no counter increment, bubble into EX.

Reset
REQ-030 SHALL on rst=1 at a clock edge clear both slot valids, state to RUN, stall_cnt to 0.
REQ-031 SHALL during rst=1 output stall=0, fwd_a=fwd_b=00 (slot contents ignored).
REQ-032 SHALL discard in-flight slots on reset mid-stall; first cycle after reset is RUN with no hazards.

Configuration
REQ-033 SHALL use macro PIPE_HAZARD_FWD_EN to compile forwarding in or out.
REQ-034 With PIPE_HAZARD_FWD_EN defined: EX-slot match of non-load forwards 01; MEM-slot match forwards 10; EX-slot match of load stalls exactly 1 cycle, then forwards 10.
REQ-035 Without PIPE_HAZARD_FWD_EN: any EX or MEM match stalls; fwd_a, fwd_b constant 00; a dependent instruction waits until producer retires (up to 2 stall cycles).

Verification
REQ-036 Bench SHALL check: add $3 then add uses rs=$3 next cycle, FWD_EN -> stall=0, fwd_a=01; no FWD_EN -> 2 stall cycles, stall_cnt=2, then fwd_a=00.
REQ-037 Bench SHALL check: lw $5 then add uses rt=$5, FWD_EN -> stall=1 for 1 cycle, in_stall=1 next cycle, then fwd_b=10, stall_cnt=1.
REQ-038 Bench SHALL check: addi $0 then consumer of $0 -> stall=0, fwd=00 in both configs.
REQ-039 Bench SHALL check: $4 written by two back-to-back producers, consumer reads $4 -> fwd_a=01 (EX priority).
REQ-040 Bench SHALL check: hazard present with flush=1 -> stall=0, stall_cnt unchanged, EX slot valid=0 next cycle.
REQ-041 Bench SHALL check: rst asserted during stall, then stall_cnt forced to 0xFFFF preload path via 65536+ stalls -> after rst stall_cnt=0, in_stall=0; saturation holds 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and operand-forwarding control for a
// five-stage in-order pipeline. It tracks the destinations of the two
// instructions in flight (EX and MEM) and compares them with the sources of
// the instruction in ID.
//
// The optional forwarding network is compiled in by defining the macro
// PIPE_HAZARD_FWD_EN. In the default build (macro undefined), any dependence
// on an in-flight producer stalls ID until that producer retires, and
// fwd_a/fwd_b stay at 00 (register file).
module pipe_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             in_stall
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // One in-flight producer: whether it will write, where, and whether the
  // value comes from memory (and so is not ready at the end of EX).
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            load;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  slot_t            ex_q,  ex_d;
  slot_t            mem_q, mem_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Register $0 is hard-wired to zero, so it never creates a dependence.
  function automatic logic slot_match(input logic            valid,
                                      input logic [RA_W-1:0] dest,
                                      input logic [RA_W-1:0] src,
                                      input logic            used);
    return valid && used && (src != '0) && (dest == src);
  endfunction

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  assign ex_hit_a  = slot_match(ex_q.valid,  ex_q.dest,  id_rs, id_use_rs);
  assign ex_hit_b  = slot_match(ex_q.valid,  ex_q.dest,  id_rt, id_use_rt);
  assign mem_hit_a = slot_match(mem_q.valid, mem_q.dest, id_rs, id_use_rs);
  assign mem_hit_b = slot_match(mem_q.valid, mem_q.dest, id_rt, id_use_rt);

  // A producer in MEM has its result available whether or not it is a load,
  // and without forwarding the load flag plays no part at all.
  logic unused_load_bits;
  assign unused_load_bits = ex_q.load ^ mem_q.load;

  // Hazard decision: stall and operand selects from the slots and the ID instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    stall = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst && id_valid && !flush) begin
`ifdef PIPE_HAZARD_FWD_EN
      // The EX slot is the youngest producer, so it is tested first. A load in
      // EX has no data yet: hold one cycle, after which it sits in MEM.
      if (ex_hit_a) begin
        if (ex_q.load) stall = 1'b1;
        else           fwd_a = FWD_EX;
      end else if (mem_hit_a) begin
        fwd_a = FWD_MEM;
      end
      if (ex_hit_b) begin
        if (ex_q.load) stall = 1'b1;
        else           fwd_b = FWD_EX;
      end else if (mem_hit_b) begin
        fwd_b = FWD_MEM;
      end
`else
      // No bypass paths: wait until the producer has written the register file.
      stall = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
`endif
    end
  end

  // Next-state values: advance the slots, insert the ID instruction or a bubble.
  always_comb begin
    ex_d.valid = id_valid & id_wr & ~stall & ~flush;
    ex_d.dest  = id_dest;
    ex_d.load  = id_load;
    mem_d      = ex_q;
    state_d    = stall ? STALL : RUN;
    cnt_d      = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State registers; reset clears the slot valids, the FSM and the counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      // NOTE: only valid bits are reset; dest/load are don't-care while invalid.
      ex_q.valid  <= 1'b0;
      mem_q.valid <= 1'b0;
      state_q     <= RUN;
      cnt_q       <= '0;
    end else begin
      ex_q.valid  <= ex_d.valid;
      mem_q.valid <= mem_d.valid;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
    ex_q.dest  <= ex_d.dest;
    ex_q.load  <= ex_d.load;
    mem_q.dest <= mem_d.dest;
    mem_q.load <= mem_d.load;
  end

  assign stall_cnt = cnt_q;
  assign in_stall  = (state_q == STALL);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a model that keeps a short history of issued instructions.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int RA_W    = 5;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            id_valid, id_use_rs, id_use_rt, id_wr, id_load, flush;
  logic [RA_W-1:0] id_rs, id_rt, id_dest;

  logic             stall, in_stall;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  logic             sat_stall, sat_in_stall;
  logic [1:0]       sat_fwd_a, sat_fwd_b;
  logic [SAT_W-1:0] sat_cnt;

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .in_stall(in_stall)
  );

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(sat_stall),
    .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b), .stall_cnt(sat_cnt),
    .in_stall(sat_in_stall)
  );

  typedef struct {
    bit            valid;
    bit [RA_W-1:0] rs, rt, dest;
    bit            use_rs, use_rt, wr, load, flush;
  } instr_t;

  typedef struct {
    bit            valid;
    bit [RA_W-1:0] dest;
    bit            load;
  } issue_t;

  // Model state: recent[0] issued one cycle ago, recent[1] two cycles ago.
  issue_t      recent[$];
  bit          m_in_stall;
  int unsigned m_cnt;
  bit          e_stall;
  bit [1:0]    e_fwd_a, e_fwd_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic instr_t mk(input int rs, input bit urs, input int rt, input bit urt,
                                input int dest, input bit wr, input bit load, input bit fl);
    instr_t i;
    i.valid = 1'b1;
    i.rs = RA_W'(rs);  i.use_rs = urs;
    i.rt = RA_W'(rt);  i.use_rt = urt;
    i.dest = RA_W'(dest); i.wr = wr; i.load = load; i.flush = fl;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_dest = i.dest; id_wr = i.wr; id_load = i.load; flush = i.flush;
  endtask

  // Youngest earlier writer of src decides: how many cycles ago it issued and
  // whether it was a load.
  function automatic void resolve(input bit [RA_W-1:0] src, input bit used,
                                  output bit st, output bit [1:0] fw);
    st = 1'b0;
    fw = 2'b00;
    if (!used || src == 0) return;
    for (int age = 1; age <= recent.size(); age++) begin
      if (recent[age-1].valid && recent[age-1].dest == src) begin
`ifdef PIPE_HAZARD_FWD_EN
        if (age == 1 && recent[0].load) st = 1'b1;
        else fw = (age == 1) ? 2'b01 : 2'b10;
`else
        st = 1'b1;
`endif
        return;
      end
    end
  endfunction

  task automatic compute_expect();
    bit sa, sb;
    e_stall = 1'b0; e_fwd_a = 2'b00; e_fwd_b = 2'b00;
    if (!rst && id_valid && !flush) begin
      resolve(id_rs, id_use_rs, sa, e_fwd_a);
      resolve(id_rt, id_use_rt, sb, e_fwd_b);
      e_stall = sa | sb;
    end
  endtask

  // Mid-cycle: compare both instances against the model.
  task automatic settle();
    int unsigned sat_exp;
    #4;
    compute_expect();
    sat_exp = (m_cnt > SAT_MAX) ? SAT_MAX : m_cnt;
    check("stall",     stall,      e_stall);
    check("fwd_a",     fwd_a,      e_fwd_a);
    check("fwd_b",     fwd_b,      e_fwd_b);
    check("stall_cnt", stall_cnt,  m_cnt);
    check("in_stall",  in_stall,   m_in_stall);
    check("sat_stall", sat_stall,  e_stall);
    check("sat_fwd_a", sat_fwd_a,  e_fwd_a);
    check("sat_fwd_b", sat_fwd_b,  e_fwd_b);
    check("sat_cnt",   sat_cnt,    sat_exp);
    check("sat_in_st", sat_in_stall, m_in_stall);
  endtask

  // Clock edge: advance the model the way the pipeline advances.
  task automatic edge_();
    issue_t n;
    @(posedge clk);
    if (rst) begin
      recent.delete();
      m_in_stall = 1'b0;
      m_cnt = 0;
    end else begin
      n.valid = id_valid && id_wr && !e_stall && !flush;
      n.dest  = id_dest;
      n.load  = id_load;
      recent.push_front(n);
      if (recent.size() > 2) void'(recent.pop_back());
      m_in_stall = e_stall;
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic step(input instr_t i);
    drive(i);
    settle();
    edge_();
  endtask

  task automatic do_reset();
    instr_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    idle.valid = 1'b0;
    rst = 1'b1;
    step(idle);
    rst = 1'b0;
  endtask

  task automatic directed();
    instr_t c;
    // ALU producer of $3, consumer reads rs=$3 on the next cycle.
    do_reset();
    step(mk(0, 0, 0, 0, 3, 1, 0, 0));
    c = mk(3, 1, 0, 0, 7, 1, 0, 0);
    drive(c); settle();
`ifdef PIPE_HAZARD_FWD_EN
    check("alu_use_stall", stall, 1'b0);
    check("alu_use_fwd_a", fwd_a, 2'b01);
    edge_();
`else
    check("alu_use_stall1", stall, 1'b1);
    edge_(); settle();
    check("alu_use_stall2", stall, 1'b1);
    check("alu_use_in_stall", in_stall, 1'b1);
    edge_(); settle();
    check("alu_use_release", stall, 1'b0);
    check("alu_use_fwd_a", fwd_a, 2'b00);
    check("alu_use_cnt", stall_cnt, 16'd2);
    edge_();
`endif

    // Load of $5, consumer reads rt=$5.
    do_reset();
    step(mk(0, 0, 0, 0, 5, 1, 1, 0));
    c = mk(0, 0, 5, 1, 8, 1, 0, 0);
    drive(c); settle();
    check("load_use_stall", stall, 1'b1);
    edge_(); settle();
    check("load_use_in_stall", in_stall, 1'b1);
`ifdef PIPE_HAZARD_FWD_EN
    check("load_use_release", stall, 1'b0);
    check("load_use_fwd_b", fwd_b, 2'b10);
    check("load_use_cnt", stall_cnt, 16'd1);
    edge_();
`else
    check("load_use_stall2", stall, 1'b1);
    edge_(); settle();
    check("load_use_release", stall, 1'b0);
    check("load_use_cnt", stall_cnt, 16'd2);
    edge_();
`endif

    // Writes to $0 never create a dependence.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 1, 0, 1, 2, 1, 0, 0)); settle();
    check("r0_stall", stall, 1'b0);
    check("r0_fwd_a", fwd_a, 2'b00);
    check("r0_fwd_b", fwd_b, 2'b00);
    edge_();

    // Two back-to-back producers of $4: the younger one (EX) is selected.
    do_reset();
    step(mk(0, 0, 0, 0, 4, 1, 0, 0));
    step(mk(0, 0, 0, 0, 4, 1, 0, 0));
    drive(mk(4, 1, 0, 0, 2, 1, 0, 0)); settle();
`ifdef PIPE_HAZARD_FWD_EN
    check("ex_prio_fwd_a", fwd_a, 2'b01);
    check("ex_prio_stall", stall, 1'b0);
`else
    check("ex_prio_stall", stall, 1'b1);
`endif
    edge_();

    // Hazard coinciding with flush: flush wins, the killed instruction leaves a bubble.
    do_reset();
    step(mk(0, 0, 0, 0, 6, 1, 0, 0));
    drive(mk(6, 1, 0, 0, 9, 1, 1, 1)); settle();
    check("flush_stall", stall, 1'b0);
    check("flush_fwd_a", fwd_a, 2'b00);
    edge_();
    drive(mk(9, 1, 9, 1, 0, 0, 0, 0)); settle();
    check("flush_cnt", stall_cnt, 16'd0);
    check("flush_bubble_stall", stall, 1'b0);
    check("flush_bubble_fwd_a", fwd_a, 2'b00);
    edge_();

    // Reset while the FSM is in STALL: slots discarded, counter cleared.
    do_reset();
    step(mk(0, 0, 0, 0, 5, 1, 1, 0));
    c = mk(0, 0, 5, 1, 8, 1, 0, 0);
    step(c);
    drive(c); settle();
    check("rst_mid_in_stall", in_stall, 1'b1);
    rst = 1'b1;
    settle();
    check("rst_hold_stall", stall, 1'b0);
    check("rst_hold_fwd_b", fwd_b, 2'b00);
    edge_();
    rst = 1'b0;
    settle();
    check("rst_after_cnt", stall_cnt, 16'd0);
    check("rst_after_in_stall", in_stall, 1'b0);
    check("rst_after_stall", stall, 1'b0);
    edge_();

    // Self-dependent load stream: counter keeps counting, narrow copy saturates.
    do_reset();
    for (int k = 0; k < 60; k++) step(mk(1, 1, 0, 0, 1, 1, 1, 0));
    settle();
    check("sat_all_ones", sat_cnt, 4'hF);
    check("cnt_past_sat", stall_cnt > 16'd15, 1'b1);
    edge_();
  endtask

  task automatic random_phase(input int n);
    instr_t cur;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      // A stalled instruction stays in ID, as the real pipeline would hold it.
      if (!e_stall || $urandom_range(0, 7) == 0) begin
        cur.valid  = ($urandom_range(0, 7) != 0);
        cur.rs     = RA_W'($urandom_range(0, 3));
        cur.rt     = RA_W'($urandom_range(0, 3));
        cur.use_rs = $urandom_range(0, 3) != 0;
        cur.use_rt = $urandom_range(0, 1) != 0;
        cur.dest   = RA_W'($urandom_range(0, 3));
        cur.wr     = $urandom_range(0, 3) != 0;
        cur.load   = $urandom_range(0, 2) == 0;
        cur.flush  = $urandom_range(0, 7) == 0;
      end
      rst = ($urandom_range(0, 63) == 0);
      step(cur);
    end
    rst = 1'b0;
  endtask

  initial begin
    instr_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    idle.valid = 1'b0;
    drive(idle);
    rst = 1'b1;
    recent.delete();
    m_in_stall = 1'b0;
    m_cnt = 0;
    e_stall = 1'b0;
    @(posedge clk);
    #1;
    settle();
    check("reset_cnt", stall_cnt, 16'd0);
    check("reset_in_stall", in_stall, 1'b0);
    edge_();
    rst = 1'b0;

    directed();
    do_reset();
    random_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
